// File: rtl/fir_pkg.sv
// fir_pkg: FSM encoding, pipeline latency and accumulator sizing shared by the
// fir_mem_engine sources.
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // BRAM read, multiply register, adder-tree register
   localparam int PIPE_LAT = 3;

   function automatic int acc_w(input int data_w, input int coef_w, input int taps);
      return data_w + coef_w + $clog2(taps);
   endfunction

endpackage

// File: rtl/fir_mac_pipe.sv
// fir_mac_pipe: delay line, coefficient bank, multiply stage and adder-tree stage
// with output saturation. A result is valid exactly two clocks after its sample.
module fir_mac_pipe
   import fir_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int COEF_W    = 8,
   parameter int COEF_FRAC = 6,
   parameter int TAPS      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_sample,
   input  logic              coef_we,
   input  logic [3:0]        coef_idx,
   input  logic [COEF_W-1:0] coef_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_result,
   output logic              out_sat
);

   localparam int PW = DATA_W + COEF_W;
   localparam int AW = acc_w(DATA_W, COEF_W, TAPS);

   logic [TAPS-1:0][COEF_W-1:0] coef_q, coef_d;
   logic [TAPS-2:0][DATA_W-1:0] dly_q, dly_d;
   logic [TAPS-1:0][DATA_W-1:0] x_vec;
   logic [TAPS-1:0][PW-1:0]     prod_q, prod_d;
   logic signed [AW-1:0]        acc_q, acc_d, acc_sh;
   logic [1:0]                  vld_pipe_q, vld_pipe_d;

   // indices at or above TAPS match no slot and are dropped
   always_comb begin
      coef_d = coef_q;
      for (int k = 0; k < TAPS; k++)
         if (coef_we && int'(coef_idx) == k) coef_d[k] = coef_data;
   end

   always_comb begin
      x_vec[0] = in_sample;
      for (int k = 1; k < TAPS; k++) x_vec[k] = dly_q[k-1];
      dly_d = dly_q;
      if (clr) begin
         dly_d = '0;
      end else if (in_valid) begin
         dly_d[0] = in_sample;
         for (int k = 1; k < TAPS-1; k++) dly_d[k] = dly_q[k-1];
      end
   end

   always_comb begin
      for (int k = 0; k < TAPS; k++)
         prod_d[k] = $signed(PW'($signed(x_vec[k]))) * $signed(PW'($signed(coef_q[k])));
      acc_d = '0;
      for (int k = 0; k < TAPS; k++) acc_d = acc_d + AW'($signed(prod_q[k]));
      vld_pipe_d = {vld_pipe_q[0], in_valid};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         coef_q     <= '0;
         dly_q      <= '0;
         prod_q     <= '0;
         acc_q      <= '0;
         vld_pipe_q <= '0;
      end else begin
         coef_q     <= coef_d;
         dly_q      <= dly_d;
         prod_q     <= prod_d;
         acc_q      <= acc_d;
         vld_pipe_q <= vld_pipe_d;
      end
   end

   // in range only when every bit above the result sign matches it
   assign acc_sh     = acc_q >>> COEF_FRAC;
   assign out_sat    = !((&acc_sh[AW-1:DATA_W-1]) || !(|acc_sh[AW-1:DATA_W-1]));
   assign out_result = !out_sat   ? acc_sh[DATA_W-1:0] :
                       acc_sh[AW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
   assign out_valid  = vld_pipe_q[1];

endmodule

// File: rtl/fir_mem_engine.sv
// fir_mem_engine: memory-to-memory FIR, BRAM port A reads, port B writes, 1 sample/clk.
// Optional FIR_PERF_CNT_EN adds a busy-cycle counter on cycle_count.
module fir_mem_engine
   import fir_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int COEF_W    = 8,
   parameter int COEF_FRAC = 6,
   parameter int TAPS      = 4,
   parameter int ADDR_W    = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] in_base,
   input  logic [ADDR_W-1:0] out_base,
   input  logic [ADDR_W-1:0] count,
   input  logic              coef_we,
   input  logic [3:0]        coef_idx,
   input  logic [COEF_W-1:0] coef_data,
   output logic              busy,
   output logic              done,
   output logic              sat_flag,
   output logic [31:0]       cycle_count,
   output logic [ADDR_W-1:0] mem_addr_a,
   input  logic [DATA_W-1:0] mem_dout_a,
   output logic [ADDR_W-1:0] mem_addr_b,
   output logic [DATA_W-1:0] mem_din_b,
   output logic              mem_we_b
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, rd_left_q, rd_left_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, wr_left_q, wr_left_d;
   logic              rd_vld_q, rd_vld_d, sat_q, sat_d;
   logic              accept, mac_vld, mac_sat;
   logic [DATA_W-1:0] mac_res;

   assign accept = (state_q == IDLE) && start;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (count == '0) ? DONE : RUN;
         RUN:     if (rd_left_q == ADDR_W'(1)) state_d = DRAIN;
         DRAIN:   if (mac_vld && wr_left_q == ADDR_W'(1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         RUN, DRAIN: busy = 1'b1;
         DONE:       done = 1'b1;
         default:    ;
      endcase
   end

   // read side runs ahead; write side follows the pipeline valid
   always_comb begin
      rd_addr_d = rd_addr_q;
      rd_left_d = rd_left_q;
      wr_addr_d = wr_addr_q;
      wr_left_d = wr_left_q;
      sat_d     = sat_q;
      rd_vld_d  = (state_q == RUN);
      if (accept) begin
         rd_addr_d = in_base;
         rd_left_d = count;
         wr_addr_d = out_base;
         wr_left_d = count;
         sat_d     = 1'b0;
      end
      if (state_q == RUN) begin
         rd_addr_d = rd_addr_q + ADDR_W'(1);
         rd_left_d = rd_left_q - ADDR_W'(1);
      end
      if (mac_vld) begin
         wr_addr_d = wr_addr_q + ADDR_W'(1);
         wr_left_d = wr_left_q - ADDR_W'(1);
         if (mac_sat) sat_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_addr_q <= '0;
         rd_left_q <= '0;
         wr_addr_q <= '0;
         wr_left_q <= '0;
         rd_vld_q  <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         rd_addr_q <= rd_addr_d;
         rd_left_q <= rd_left_d;
         wr_addr_q <= wr_addr_d;
         wr_left_q <= wr_left_d;
         rd_vld_q  <= rd_vld_d;
         sat_q     <= sat_d;
      end
   end

   fir_mac_pipe #(
      .DATA_W    (DATA_W),
      .COEF_W    (COEF_W),
      .COEF_FRAC (COEF_FRAC),
      .TAPS      (TAPS)
   ) u_mac (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (accept),
      .in_valid   (rd_vld_q),
      .in_sample  (mem_dout_a),
      .coef_we    (coef_we && (state_q == IDLE)),
      .coef_idx   (coef_idx),
      .coef_data  (coef_data),
      .out_valid  (mac_vld),
      .out_result (mac_res),
      .out_sat    (mac_sat)
   );

   assign mem_addr_a = rd_addr_q;
   assign mem_addr_b = wr_addr_q;
   assign mem_din_b  = mac_res;
   assign mem_we_b   = mac_vld && busy;
   assign sat_flag   = sat_q;

`ifdef FIR_PERF_CNT_EN
   logic [31:0] cyc_q, cyc_d;

   always_comb begin
      cyc_d = cyc_q;
      if (accept)    cyc_d = '0;
      else if (busy) cyc_d = cyc_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cyc_q <= '0;
      else        cyc_q <= cyc_d;
   end

   assign cycle_count = cyc_q;
`else
   assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_fir_mem_engine.sv
// tb_fir_mem_engine: table-driven and randomized runs against an integer FIR model,
// plus hand sequences for mid-run start/coef writes, mid-run reset and count=0.
module tb_fir_mem_engine;

   logic        clk = 1'b0;
   logic        rst_n, start, coef_we;
   logic [9:0]  in_base, out_base, count, mem_addr_a, mem_addr_b;
   logic [3:0]  coef_idx;
   logic [7:0]  coef_data, mem_dout_a, mem_din_b;
   logic        busy, done, sat_flag, mem_we_b;
   logic [31:0] cycle_count;

   logic [7:0]  img [0:1023];
   int          coef_m [4];
   int          y_exp [0:1023];
   int          sat_exp;
   int          n_chk = 0;
   int          n_pass = 0;

   typedef struct {
      int c0, c1, c2, c3;
      int ib, ob, cnt;
      int pat, pval;
      int exp_y0;    // -999: take from model
      int exp_sat;   // -1: take from model
   } vec_t;
   vec_t vecs [6];

   fir_mem_engine dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_base(in_base), .out_base(out_base),
      .count(count), .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
      .busy(busy), .done(done), .sat_flag(sat_flag), .cycle_count(cycle_count),
      .mem_addr_a(mem_addr_a), .mem_dout_a(mem_dout_a), .mem_addr_b(mem_addr_b),
      .mem_din_b(mem_din_b), .mem_we_b(mem_we_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) mem_dout_a <= img[mem_addr_a];

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
      int c [4];
      c = '{c0, c1, c2, c3};
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         coef_we = 1'b1; coef_idx = 4'(k); coef_data = 8'(c[k]); coef_m[k] = c[k];
      end
      @(negedge clk);
      coef_idx = 4'd9; coef_data = 8'h55;
      @(negedge clk);
      coef_we = 1'b0;
   endtask

   task automatic fill(input int ib, input int cnt, input int pat, input int pval);
      int v;
      for (int n = 0; n < cnt; n++) begin
         case (pat)
            0:       v = n + 1;
            1:       v = pval;
            2:       v = pval * (n + 1);
            default: v = int'($urandom_range(0, 255)) - 128;
         endcase
         img[(ib + n) % 1024] = 8'(v);
      end
   endtask

   task automatic model(input int ib, input int cnt);
      int acc, v;
      sat_exp = 0;
      for (int n = 0; n < cnt; n++) begin
         acc = 0;
         for (int k = 0; k < 4; k++)
            if (n - k >= 0) acc += coef_m[k] * int'($signed(img[(ib + n - k) % 1024]));
         v = acc >>> 6;
         if (v > 127) begin v = 127; sat_exp = 1; end
         else if (v < -128) begin v = -128; sat_exp = 1; end
         y_exp[n] = v;
      end
   endtask

   // dkind: 0 plain, 1 start+coef_we pulsed mid-run and start in DONE, 2 reset at cycle dcyc
   task automatic run(input int ib, input int ob, input int cnt, input int dkind,
                      input int dcyc, input int exp_sat, input string tag);
      int wi, done_n, done_at, busy_n, bad_we, rd_bad, nexp, exp_cc;
      wi = 0; done_n = 0; done_at = -1; busy_n = 0; bad_we = 0; rd_bad = 0;
      nexp = cnt;
      if (dkind == 2) nexp = (dcyc - 3 < cnt) ? dcyc - 3 : cnt;
      @(negedge clk);
      in_base = 10'(ib); out_base = 10'(ob); count = 10'(cnt); start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= cnt + 8; k++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (done) begin done_n++; done_at = k; end
         if (k <= cnt && !(dkind == 2 && k > dcyc))
            if (int'(mem_addr_a) != (ib + k - 1) % 1024) rd_bad++;
         if (mem_we_b) begin
            if (!busy) bad_we++;
            if (wi < nexp) begin
               check({tag, " y"},      int'($signed(mem_din_b)), y_exp[wi]);
               check({tag, " waddr"},  int'(mem_addr_b), (ob + wi) % 1024);
               check({tag, " wcycle"}, k, wi + 4);
            end
            wi++;
         end
         if (dkind == 1 && k == dcyc) begin
            start = 1'b1; in_base = 10'(ib + 7); count = 10'd5;
            coef_we = 1'b1; coef_idx = 4'd0; coef_data = 8'd10;
         end
         if (dkind == 1 && k == cnt + 4) start = 1'b1;
         if (dkind == 1 && (k == dcyc + 1 || k == cnt + 5)) begin start = 1'b0; coef_we = 1'b0; end
         if (dkind == 2 && k == dcyc) rst_n = 1'b0;
         if (dkind == 2 && k == dcyc + 1) rst_n = 1'b1;
      end
      check({tag, " writes"}, wi, nexp);
      check({tag, " rd_addr_errs"}, rd_bad, 0);
      check({tag, " we_outside_busy"}, bad_we, 0);
      check({tag, " done_pulses"}, done_n, (dkind == 2) ? 0 : 1);
      if (dkind != 2) check({tag, " done_cycle"}, done_at, (cnt == 0) ? 1 : cnt + 4);
      check({tag, " busy_cycles"}, busy_n, (dkind == 2) ? dcyc : ((cnt == 0) ? 0 : cnt + 3));
      check({tag, " sat_flag"}, int'(sat_flag), (dkind == 2) ? 0 : exp_sat);
`ifdef FIR_PERF_CNT_EN
      exp_cc = (dkind == 2 || cnt == 0) ? 0 : cnt + 3;
`else
      exp_cc = 0;
`endif
      check({tag, " cycle_count"}, int'(cycle_count), exp_cc);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; coef_we = 1'b0; coef_idx = '0; coef_data = '0;
      in_base = '0; out_base = '0; count = '0;
      for (int i = 0; i < 1024; i++) img[i] = 8'h00;

      vecs[0] = '{64, 0, 0, 0,         0,    32,  20, 0, 0,    1,    0};
      vecs[1] = '{32, 32, 0, 0,        100,  200, 3,  2, 10,   5,    0};
      vecs[2] = '{127, 127, 127, 127,  300,  400, 8,  1, 127,  127,  1};
      vecs[3] = '{127, 127, 127, 127,  310,  410, 8,  1, -128, -128, 1};
      vecs[4] = '{64, 0, 0, 0,         1022, 1020, 4, 3, 0,    -999, 0};
      vecs[5] = '{-20, 50, 33, -7,     700,  800, 1,  3, 0,    -999, -1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst busy",        int'(busy), 0);
      check("rst done",        int'(done), 0);
      check("rst sat_flag",    int'(sat_flag), 0);
      check("rst mem_we_b",    int'(mem_we_b), 0);
      check("rst mem_addr_a",  int'(mem_addr_a), 0);
      check("rst mem_addr_b",  int'(mem_addr_b), 0);
      check("rst mem_din_b",   int'(mem_din_b), 0);
      check("rst cycle_count", int'(cycle_count), 0);
      rst_n = 1'b1;

      for (int v = 0; v < 6; v++) begin
         set_coefs(vecs[v].c0, vecs[v].c1, vecs[v].c2, vecs[v].c3);
         fill(vecs[v].ib, vecs[v].cnt, vecs[v].pat, vecs[v].pval);
         model(vecs[v].ib, vecs[v].cnt);
         if (vecs[v].exp_y0 != -999) y_exp[0] = vecs[v].exp_y0;
         run(vecs[v].ib, vecs[v].ob, vecs[v].cnt, 0, 0,
             (vecs[v].exp_sat >= 0) ? vecs[v].exp_sat : sat_exp, $sformatf("vec%0d", v));
      end

      for (int r = 0; r < 6; r++) begin
         int ib, ob, cnt;
         ib  = int'($urandom_range(0, 1023));
         ob  = int'($urandom_range(0, 1023));
         cnt = int'($urandom_range(1, 40));
         set_coefs(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                   int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
         fill(ib, cnt, 3, 0);
         model(ib, cnt);
         run(ib, ob, cnt, 0, 0, sat_exp, $sformatf("rnd%0d", r));
      end

      set_coefs(64, 0, 0, 0);
      fill(50, 10, 3, 0);
      model(50, 10);
      run(50, 150, 10, 1, 3, 0, "midrun");
      fill(60, 5, 3, 0);
      model(60, 5);
      run(60, 160, 5, 0, 0, 0, "coefkeep");

      fill(0, 20, 0, 0);
      model(0, 20);
      run(0, 32, 20, 2, 5, 0, "rstrun");
      run(0, 32, 0, 0, 0, 0, "cnt0");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
